// File: rtl/contador_modulo_controller.sv
// contador_modulo_controller: run controller around a modulo-M up/down counter.
// The modulus, direction and repeat mode are captured when a run starts. Rev 1.0.
`default_nettype none

module contador_modulo_controller #(
   parameter int WIDTH       = 4,
   parameter int DEFAULT_MOD = 9
) (
   input  logic             clk_input,
   input  logic             clear_input,
   input  logic             start_input,
   input  logic             stop_input,
   input  logic             pause_input,
   input  logic [WIDTH-1:0] modulo_input,
   input  logic             down_input,
   input  logic             repeat_input,
   output logic [WIDTH-1:0] contador_output,
   output logic             busy_output,
   output logic             terminal_output,
   output logic             done_output,
   output logic [7:0]       wraps_output,
   output logic [1:0]       state_output
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_RUN   = 2'b01,
      ST_PAUSE = 2'b10,
      ST_DONE  = 2'b11
   } state_t;

   localparam logic [WIDTH-1:0] DEF_M = WIDTH'(DEFAULT_MOD);
   localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);
   localparam logic [WIDTH-1:0] TWO   = WIDTH'(2);

   state_t           state, state_nxt;
   logic [WIDTH-1:0] count, count_nxt;
   logic [WIDTH-1:0] modulus, modulus_nxt;
   logic             down, down_nxt;
   logic             rep, rep_nxt;
   logic [7:0]       wraps, wraps_nxt;

   logic [WIDTH-1:0] start_mod;
   logic [WIDTH-1:0] top_val;
   logic [WIDTH-1:0] term_val;
   logic             at_term;

   // Moduli 0 and 1 cannot form a meaningful cycle, so they fall back to the default.
   assign start_mod = (modulo_input < TWO) ? DEF_M : modulo_input;
   assign top_val   = modulus - ONE;
   assign term_val  = down ? '0 : top_val;
   assign at_term   = (count == term_val);

   always_comb begin
      state_nxt   = state;
      count_nxt   = count;
      modulus_nxt = modulus;
      down_nxt    = down;
      rep_nxt     = rep;
      wraps_nxt   = wraps;
      unique case (state)
         ST_IDLE: begin
            if (start_input && !stop_input) begin
               modulus_nxt = start_mod;
               down_nxt    = down_input;
               rep_nxt     = repeat_input;
               count_nxt   = down_input ? (start_mod - ONE) : '0;
               wraps_nxt   = 8'd0;
               state_nxt   = ST_RUN;
            end
         end
         ST_RUN: begin
            if (stop_input) begin
               state_nxt = ST_IDLE;
            end else if (pause_input) begin
               state_nxt = ST_PAUSE;
            end else if (at_term) begin
               if (rep) begin
                  count_nxt = down ? top_val : '0;
                  if (wraps != 8'hFF) wraps_nxt = wraps + 8'd1;
               end else begin
                  state_nxt = ST_DONE;
               end
            end else begin
               count_nxt = down ? (count - ONE) : (count + ONE);
            end
         end
         ST_PAUSE: begin
            if (stop_input) begin
               state_nxt = ST_IDLE;
            end else if (!pause_input) begin
               state_nxt = ST_RUN;
            end
         end
         ST_DONE: begin
            state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_input) begin
      if (clear_input) begin
         state   <= ST_IDLE;
         count   <= '0;
         modulus <= DEF_M;
         down    <= 1'b0;
         rep     <= 1'b0;
         wraps   <= 8'd0;
      end else begin
         state   <= state_nxt;
         count   <= count_nxt;
         modulus <= modulus_nxt;
         down    <= down_nxt;
         rep     <= rep_nxt;
         wraps   <= wraps_nxt;
      end
   end

   assign contador_output = count;
   assign wraps_output    = wraps;
   assign state_output    = state;
   assign busy_output     = (state == ST_RUN) || (state == ST_PAUSE);
   assign done_output     = (state == ST_DONE);
   assign terminal_output = (state == ST_RUN) && !pause_input && !stop_input && at_term;

endmodule

`default_nettype wire

// File: tb/tb_contador_modulo_controller.sv
// Bench for contador_modulo_controller: directed scenarios plus random traffic,
// all outputs compared every cycle against an arithmetic reference model.
`default_nettype none

module tb_contador_modulo_controller;

   localparam int W   = 4;
   localparam int DEF = 9;

   logic         clk = 1'b0;
   logic         clear, start, stop, pause, down, rep;
   logic [W-1:0] modulo;
   logic [W-1:0] contador;
   logic         busy, terminal, done;
   logic [7:0]   wraps;
   logic [1:0]   state;

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   // Reference model: phase 0 idle, 1 run, 2 paused, 3 done
   int m_phase, m_cnt, m_wraps, m_mod;
   bit m_down, m_rep;

   contador_modulo_controller #(.WIDTH(W), .DEFAULT_MOD(DEF)) dut (
      .clk_input       (clk),
      .clear_input     (clear),
      .start_input     (start),
      .stop_input      (stop),
      .pause_input     (pause),
      .modulo_input    (modulo),
      .down_input      (down),
      .repeat_input    (rep),
      .contador_output (contador),
      .busy_output     (busy),
      .terminal_output (terminal),
      .done_output     (done),
      .wraps_output    (wraps),
      .state_output    (state)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic bit model_terminal();
      int last;
      last = m_down ? 0 : m_mod - 1;
      return (m_phase == 1) && !pause && !stop && (m_cnt == last);
   endfunction

   task automatic compare_all();
      check("contador", 32'(contador), 32'(m_cnt));
      check("state",    32'(state),    32'(m_phase));
      check("busy",     32'(busy),     32'((m_phase == 1) || (m_phase == 2)));
      check("done",     32'(done),     32'(m_phase == 3));
      check("wraps",    32'(wraps),    32'(m_wraps));
      check("terminal", 32'(terminal), 32'(model_terminal()));
   endtask

   task automatic model_edge();
      bit last;
      if (clear) begin
         m_phase = 0; m_cnt = 0; m_wraps = 0; m_mod = DEF; m_down = 0; m_rep = 0;
      end else begin
         case (m_phase)
            0: if (start && !stop) begin
                  m_mod   = (int'(modulo) < 2) ? DEF : int'(modulo);
                  m_down  = down;
                  m_rep   = rep;
                  m_cnt   = down ? m_mod - 1 : 0;
                  m_wraps = 0;
                  m_phase = 1;
               end
            1: if (stop) m_phase = 0;
               else if (pause) m_phase = 2;
               else begin
                  last = m_down ? (m_cnt == 0) : (m_cnt == m_mod - 1);
                  if (last && !m_rep) m_phase = 3;
                  else begin
                     m_cnt = m_down ? (m_cnt + m_mod - 1) % m_mod : (m_cnt + 1) % m_mod;
                     if (last && m_wraps < 255) m_wraps++;
                  end
               end
            2: if (stop) m_phase = 0;
               else if (!pause) m_phase = 1;
            default: m_phase = 0;
         endcase
      end
   endtask

   // Apply inputs, compare pre-edge outputs, clock once, advance the model.
   task automatic drive(input bit c, input bit st, input bit sp, input bit ps,
                        input int md, input bit dn, input bit rp);
      clear = c; start = st; stop = sp; pause = ps;
      modulo = W'(md); down = dn; rep = rp;
      #1;
      if (chk_en) compare_all();
      @(posedge clk);
      model_edge();
      @(negedge clk);
   endtask

   // Plain cycles with junk on the run-configuration inputs, which must be ignored while busy.
   task automatic tick(input int n);
      for (int i = 0; i < n; i++)
         drive(0, 0, 0, 0, int'($urandom_range(0, 15)), 1'($urandom), 1'($urandom));
   endtask

   initial begin
      clear = 1; start = 0; stop = 0; pause = 0; modulo = '0; down = 0; rep = 0;
      @(negedge clk);
      drive(1, 0, 0, 0, 0, 0, 0);
      chk_en = 1'b1;
      check("reset_state", 32'(state), 32'd0);
      check("reset_count", 32'(contador), 32'd0);

      // One-shot up, M=9
      drive(0, 1, 0, 0, 9, 0, 0);
      tick(9);
      check("p1_done", 32'(done), 32'd1);
      check("p1_hold8", 32'(contador), 32'd8);
      tick(1);
      check("p1_idle_busy", 32'(busy), 32'd0);
      tick(2);

      // Repeating up, M=9
      drive(0, 1, 0, 0, 9, 0, 1);
      tick(20);
      check("p2_wraps", 32'(wraps), 32'd2);
      check("p2_busy", 32'(busy), 32'd1);
      drive(0, 0, 1, 0, 0, 0, 0);

      // Repeating down, M=5
      drive(0, 1, 0, 0, 5, 1, 1);
      check("p3_first", 32'(contador), 32'd4);
      tick(7);
      check("p3_wraps", 32'(wraps), 32'd1);
      drive(0, 0, 1, 0, 0, 0, 0);

      // Pause at 3
      drive(0, 1, 0, 0, 9, 0, 0);
      tick(3);
      for (int i = 0; i < 3; i++) drive(0, 0, 0, 1, 9, 0, 0);
      check("p4_paused", 32'(state), 32'd2);
      check("p4_held", 32'(contador), 32'd3);
      tick(4);
      drive(0, 0, 1, 0, 0, 0, 0);

      // Stop at 5, start while busy, invalid modulus
      drive(0, 1, 0, 0, 9, 0, 1);
      tick(3);
      drive(0, 1, 0, 0, 3, 1, 0);
      tick(1);
      check("p5_at5", 32'(contador), 32'd5);
      drive(0, 0, 1, 0, 0, 0, 0);
      check("p5_stopped", 32'(state), 32'd0);
      check("p5_kept5", 32'(contador), 32'd5);
      tick(2);
      drive(0, 1, 0, 0, 0, 1, 0);
      check("p5_defmod", 32'(contador), 32'd8);
      tick(4);

      // Clear mid-run, then clear together with start
      drive(0, 1, 0, 0, 9, 0, 1);
      tick(6);
      drive(1, 1, 0, 0, 9, 0, 1);
      check("p6_cleared", 32'(contador), 32'd0);
      drive(1, 1, 0, 0, 9, 0, 1);
      check("p6_idle", 32'(state), 32'd0);

      // Random traffic, including short moduli for frequent wraps
      for (int i = 0; i < 4000; i++) begin
         drive(($urandom_range(0, 99) == 0),
               ($urandom_range(0, 3) == 0),
               ($urandom_range(0, 24) == 0),
               ($urandom_range(0, 7) == 0),
               int'($urandom_range(0, 15)),
               1'($urandom), ($urandom_range(0, 3) != 0));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/contador_modulo_controller.md
Name: contador_modulo_controller

Overview:
- Sequences a programmable modulo-M up/down counter: start/stop/pause control, one-shot or repeating runs, terminal-count and completion signalling.
- Sits beside the modulo-9 T-flip-flop counter family. It replaces hard-wired wrap logic with a configurable modulus latched per run, so one counter datapath serves any modulus 2..2^WIDTH-1.

Parameters:
WIDTH, 4, counter width in bits.
DEFAULT_MOD, 9, modulus used after reset and whenever a start presents an invalid modulus (0 or 1).

Ports:
clk_input  in  1  clock; all state changes on rising edge.
clear_input  in  1  reset; synchronous, active-high, highest priority.
start_input  in  1  start request; sampled only in IDLE.
stop_input  in  1  abort current run.
pause_input  in  1  level; holds the count while high.
modulo_input  in  WIDTH  modulus M for the next run; latched on accepted start.
down_input  in  1  direction (1 = down); latched on accepted start.
repeat_input  in  1  1 = wrap forever, 0 = one-shot; latched on accepted start.
contador_output  out  WIDTH  current count.
busy_output  out  1  high in RUN and PAUSE.
terminal_output  out  1  high while the last value is shown and the next edge advances.
done_output  out  1  one-cycle pulse at the end of a one-shot run.
wraps_output  out  8  wrap counter for the current run, saturates at 255.
state_output  out  2  IDLE=00, RUN=01, PAUSE=10, DONE=11.

Behaviour:
- Reset (clear_input=1 at edge):
  - state IDLE.
  - contador 0, wraps 0.
  - latched M=DEFAULT_MOD, direction up, one-shot.
  - busy, terminal and done all 0.
- Priority at each edge: clear > stop > pause > advance/start.
- IDLE, start=1 and stop=0:
  - latch M (0 or 1 becomes DEFAULT_MOD), direction and repeat.
  - contador := 0 (up) or M-1 (down).
  - wraps := 0.
  - next state RUN.
  - The start value is shown for one full cycle before the first advance.
- IDLE, start=0 or stop=1: all outputs hold.
- RUN, no stop, no pause:
  - Every edge advances by 1.
  - Up counts 0..M-1, then wraps to 0. Down counts M-1..0, then wraps to M-1.
- Terminal value is M-1 (up) or 0 (down).
- terminal_output is combinational: state==RUN & pause_input==0 & stop_input==0 & contador==terminal value.
- Terminal edge, repeat=1: counter wraps, wraps_output += 1 (saturating at 255), stay in RUN.
- Terminal edge, repeat=0: counter holds the terminal value, no wrap, no wraps increment, next state DONE.
- DONE:
  - done_output=1 and busy=0 for exactly one cycle.
  - next state IDLE unconditionally; start is ignored in DONE.
- RUN, pause=1: no advance that edge, next state PAUSE.
- PAUSE, pause=1: hold.
- PAUSE, pause=0: next state RUN with no advance on that edge; advancing resumes on the following edge.
- RUN/PAUSE, stop=1:
  - next state IDLE, contador and wraps hold.
  - no done pulse; busy drops the next cycle.
- start while busy is ignored. modulo_input, down_input and repeat_input changes during a run are ignored.
- Counter value never reaches or exceeds M. Arithmetic is modulo M within WIDTH bits; no overflow path exists.
- clear mid-run: all outputs take their reset values at that edge, regardless of other inputs.

Test Plan:
- Reset, then start with M=9, up, one-shot → contador 0,1,...,8, one value per cycle; terminal=1 only in the cycle showing 8; next cycle state DONE, done=1, contador=8; following cycle IDLE, busy=0.
- Start with M=9, up, repeat, run 20 cycles → 0..8, 0..8, 0, 1; terminal pulses twice; wraps_output=2; busy stays 1.
- Start with M=5, down, repeat → 4,3,2,1,0,4,3; terminal high while 0 is shown; wraps=1 after the wrap.
- M=9 up run; pause high for 3 cycles while contador=3 → contador stays 3 (state PAUSE, terminal 0); after release, 3 is held one more cycle, then 4,5,...
- Stop at contador=5 → IDLE, contador=5, no done pulse. A start pulse while busy has no effect. Start with modulo_input=0 → run uses M=9.
- clear_input high mid-run at contador=6 → next edge: contador=0, state IDLE, busy/terminal/done=0, wraps=0. clear and start asserted together → stay IDLE.
